// File: rtl/handshake_fifo_if.sv
// Req/ack channel bundle for handshake_fifo: fill side pulls from the producer,
// drain side serves the graph. slave = the FIFO's view, master = the environment's view.
interface handshake_fifo_if #(
    parameter int data_width = 32
) ();
    logic                  fill_req;
    logic                  fill_ack;
    logic [data_width-1:0] fill_din;
    logic                  drain_req;
    logic                  drain_ack;
    logic [data_width-1:0] drain_dout;

    modport slave (
        output fill_req, drain_ack, drain_dout,
        input  fill_ack, fill_din, drain_req
    );

    modport master (
        input  fill_req, drain_ack, drain_dout,
        output fill_ack, fill_din, drain_req
    );
endinterface

// File: rtl/handshake_fifo.sv
// Circular req/ack elastic buffer; a word pushed on edge t is poppable on edge t+1.
// fill_req drops one cycle after every ack and stays low while full; drain acks never run back-to-back.
module handshake_fifo #(
    parameter int                    data_width    = 32,
    parameter int                    ptr_width     = 2,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    handshake_fifo_if.slave      bus,
    output logic [ptr_width:0]   level,
    output logic [ptr_width:0]   max_level,
    output logic [31:0]          push_count,
    output logic [31:0]          pop_count,
    output logic                 overflow
);
    localparam int                 depth      = 1 << ptr_width;
    localparam logic [ptr_width:0] full_level = (ptr_width + 1)'(depth);

    logic [data_width-1:0] mem [depth];
    logic [ptr_width-1:0]  wr_ptr;
    logic [ptr_width-1:0]  rd_ptr;
    logic                  fill_req_q;
    logic                  drain_ack_q;
    logic [data_width-1:0] drain_dout_q;

    logic                  push;
    logic                  drop;
    logic                  pop;
    logic [ptr_width:0]    level_next;

    always_comb begin
        push       = bus.fill_ack && (level < full_level);
        drop       = bus.fill_ack && (level == full_level);
        // Pop looks at the pre-edge level, so a word being written this edge is not yet visible.
        pop        = bus.drain_req && !drain_ack_q && (level != '0);
        level_next = level + {{ptr_width{1'b0}}, push} - {{ptr_width{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= bus.fill_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_req_q   <= 1'b0;
            drain_ack_q  <= 1'b0;
            drain_dout_q <= initial_value;
            level        <= '0;
            max_level    <= '0;
            push_count   <= '0;
            pop_count    <= '0;
            overflow     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            drain_ack_q <= 1'b0;
            // Only request when a slot is guaranteed at the producer's next sample.
            fill_req_q  <= !bus.fill_ack && (level_next < full_level);
            level       <= level_next;
            if (level_next > max_level) begin
                max_level <= level_next;
            end
            if (push) begin
                wr_ptr     <= wr_ptr + ptr_width'(1);
                push_count <= push_count + 32'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                drain_ack_q  <= 1'b1;
                drain_dout_q <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + ptr_width'(1);
                pop_count    <= pop_count + 32'd1;
            end
        end
    end

    assign bus.fill_req   = fill_req_q;
    assign bus.drain_ack  = drain_ack_q;
    assign bus.drain_dout = drain_dout_q;
endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo: depth-4 instance for fill/overflow/drain/reset/streaming,
// depth-2 instance for randomly stalled traffic on both sides.
module tb_handshake_fifo;
    localparam logic [31:0] init0 = 32'h5A5A_0001;

    logic clk;
    logic rst;

    handshake_fifo_if #(.data_width(32)) b0 ();
    handshake_fifo_if #(.data_width(16)) b1 ();

    logic [2:0]  lvl0, max0;
    logic [31:0] pushc0, popc0;
    logic        ovf0;
    logic [1:0]  lvl1, max1;
    logic [31:0] pushc1, popc1;
    logic        ovf1;

    handshake_fifo #(.data_width(32), .ptr_width(2), .initial_value(init0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0),
        .level(lvl0), .max_level(max0), .push_count(pushc0), .pop_count(popc0), .overflow(ovf0)
    );

    handshake_fifo #(.data_width(16), .ptr_width(1), .initial_value(16'h0)) dut1 (
        .clk(clk), .rst(rst), .bus(b1),
        .level(lvl1), .max_level(max1), .push_count(pushc1), .pop_count(popc1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          p_en0 = 0, c_en0 = 0, p_en1 = 0, c_en1 = 0;
    int          p_stall1 = 0, c_stall1 = 0;
    logic [31:0] nxt_in0 = 0, exp_out0 = 0, nxt_in1 = 0, exp_out1 = 0;
    int          p_acks0 = 0, pops0 = 0, p_acks1 = 0, pops1 = 0;
    int          last_ack0 = -1;
    int          space_chk = 0, lvl_chk1 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: producers/consumers decide from outputs sampled after the previous edge.
    task automatic tick();
        b0.fill_ack = 1'b0;
        if (p_en0 != 0 && b0.fill_req === 1'b1) begin
            b0.fill_ack = 1'b1;
            b0.fill_din = nxt_in0;
            nxt_in0++;
            p_acks0++;
        end
        b0.drain_req = (c_en0 != 0);
        b1.fill_ack = 1'b0;
        if (p_en1 != 0 && b1.fill_req === 1'b1 && $urandom_range(0, 99) >= p_stall1) begin
            b1.fill_ack = 1'b1;
            b1.fill_din = nxt_in1[15:0];
            nxt_in1++;
            p_acks1++;
        end
        b1.drain_req = (c_en1 != 0) && ($urandom_range(0, 99) >= c_stall1);
        @(posedge clk);
        #1;
        cyc++;
        b0.fill_ack = 1'b0;
        b1.fill_ack = 1'b0;
        if (b0.drain_ack === 1'b1) begin
            check("d0_data", b0.drain_dout, exp_out0);
            exp_out0++;
            pops0++;
            if (space_chk != 0 && last_ack0 >= 0) check("d0_ack_spacing", cyc - last_ack0, 2);
            last_ack0 = cyc;
        end
        if (b1.drain_ack === 1'b1) begin
            check("d1_data", {16'h0, b1.drain_dout}, exp_out1);
            exp_out1++;
            pops1++;
        end
        if (lvl_chk1 != 0) check("d1_level_le2", {31'h0, lvl1 <= 2'd2}, 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        b0.fill_ack = 1'b0; b0.fill_din = '0; b0.drain_req = 1'b0;
        b1.fill_ack = 1'b0; b1.fill_din = '0; b1.drain_req = 1'b0;
        tick();
        tick();
        check("rst_fill_req", b0.fill_req, 0);
        check("rst_drain_ack", b0.drain_ack, 0);
        check("rst_dout", b0.drain_dout, init0);
        check("rst_level", lvl0, 0);
        check("rst_max", max0, 0);
        check("rst_push", pushc0, 0);
        check("rst_pop", popc0, 0);
        check("rst_ovf", ovf0, 0);
        rst = 1'b0;

        // Fill to full with nobody draining.
        p_en0 = 1;
        repeat (12) tick();
        check("full_level", lvl0, 4);
        check("full_max", max0, 4);
        check("full_fill_req", b0.fill_req, 0);
        check("full_drain_ack", b0.drain_ack, 0);
        check("full_push", pushc0, 4);
        check("full_ovf", ovf0, 0);
        check("full_dout", b0.drain_dout, init0);

        // Misbehaving producer acks while full.
        p_en0 = 0;
        b0.fill_ack = 1'b1;
        b0.fill_din = 32'hDEAD;
        @(posedge clk);
        #1;
        cyc++;
        b0.fill_ack = 1'b0;
        check("ovf_set", ovf0, 1);
        check("ovf_level", lvl0, 4);
        check("ovf_push", pushc0, 4);
        check("ovf_fill_req", b0.fill_req, 0);
        tick();
        check("ovf_sticky", ovf0, 1);

        // Drain from full with producer refilling.
        p_en0 = 1;
        c_en0 = 1;
        space_chk = 1;
        tick();
        check("drain_first_ack", b0.drain_ack, 1);
        check("drain_fill_req_back", b0.fill_req, 1);
        check("drain_level", lvl0, 3);
        repeat (19) tick();
        check("drain_pop", popc0, 10);
        check("drain_push", pushc0, 14);
        check("drain_level_end", lvl0, 4);
        check("drain_ovf", ovf0, 1);
        space_chk = 0;

        // Leave three words buffered, then reset with a stray ack on the reset edge.
        p_en0 = 0;
        tick();
        c_en0 = 0;
        tick();
        check("pre_rst_level", lvl0, 3);
        check("pre_rst_dout", b0.drain_dout, 10);
        rst = 1'b1;
        b0.drain_req = 1'b0;
        b0.fill_ack = 1'b1;
        b0.fill_din = 32'hBEEF;
        @(posedge clk);
        #1;
        cyc++;
        b0.fill_ack = 1'b0;
        check("mid_rst_level", lvl0, 0);
        check("mid_rst_drain_ack", b0.drain_ack, 0);
        check("mid_rst_dout", b0.drain_dout, init0);
        check("mid_rst_push", pushc0, 0);
        check("mid_rst_pop", popc0, 0);
        check("mid_rst_max", max0, 0);
        check("mid_rst_ovf", ovf0, 0);
        rst = 1'b0;
        exp_out0 = nxt_in0;
        p_acks0 = 0;
        pops0 = 0;

        // Both sides always ready, 5000 words.
        p_en0 = 1;
        c_en0 = 1;
        n = 0;
        while (pops0 < 5000 && n < 12000) begin
            tick();
            n++;
        end
        check("stream_done", pops0, 5000);
        check("stream_thru", {31'h0, n <= 10204}, 1);
        check("stream_pop", popc0, 5000);
        check("stream_push", pushc0, p_acks0);
        check("stream_max_le2", {31'h0, max0 <= 3'd2}, 1);
        check("stream_ovf", ovf0, 0);

        // Producer stops; consumer keeps requesting into an empty buffer.
        p_en0 = 0;
        repeat (6) tick();
        check("empty_level", lvl0, 0);
        check("empty_drain_ack", b0.drain_ack, 0);
        check("empty_dout_held", b0.drain_dout, exp_out0 - 1);
        check("empty_pop_eq_push", popc0, p_acks0);
        repeat (3) tick();
        check("empty_dout_held2", b0.drain_dout, exp_out0 - 1);
        check("empty_drain_ack2", b0.drain_ack, 0);
        c_en0 = 0;

        // Depth-2 buffer with 30% stalls on both sides.
        p_en1 = 1;
        c_en1 = 1;
        p_stall1 = 30;
        c_stall1 = 30;
        lvl_chk1 = 1;
        repeat (2000) tick();
        lvl_chk1 = 0;
        check("rand_ovf", ovf1, 0);
        check("rand_pop", popc1, pops1);
        check("rand_push", pushc1, p_acks1);
        check("rand_progress", {31'h0, pops1 > 200}, 1);
        check("rand_max_le2", {31'h0, max1 <= 2'd2}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
